transmissor_serial: RTL and testbench
=====================================

Name: transmissor_serial

Overview:
- Parallel-to-serial bit-stream transmitter. Produces the single-bit serial line Y consumed by the team's serial sequence detectors.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per Clk cycle, then drives GAP idle-zero cycles before accepting the next word.
- Used as the stimulus source on the send side of detector-based links and as a reusable bench driver.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- GAP, 2: idle cycles with Y=0 after each word; 0 is legal.
- MSB_FIRST, 1: 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  reset; asynchronous, active-low.
- Dado  input  WIDTH  word to transmit; sampled only on acceptance.
- Valido  input  1  Dado is valid.
- Pronto  output  1  transmitter can accept a word; equals (estado == IDLE), combinational from state.
- Y  output  1  serial data out; registered.
- Ocupado  output  1  high in SHIFT and GAP (registered/state-decoded).
- Fim  output  1  one-cycle pulse, high during the cycle the last bit of a word is on Y.

Behaviour:
- Reset (Rst=0, async): estado=IDLE, shift register=0, bit counter=0, gap counter=0, Y=0, Fim=0, Ocupado=0. Pronto=1 immediately after reset is released.
- Reset mid-word or mid-gap: transmission is aborted with no completion. Fim does not pulse. Y=0 on the next cycle after release.
- Acceptance: on a rising edge with Valido=1 and Pronto=1, Dado is captured into the shift register and estado goes to SHIFT. Valido while Pronto=0 is ignored; the word is not queued. Dado changes after acceptance have no effect.
- Latency: word accepted at edge k, so the first bit is on Y in the cycle after edge k. Bit i (i=0..WIDTH-1, in send order) is on Y in cycle k+1+i.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: Y=0. Moves to SHIFT on acceptance.
  - SHIFT: one bit per cycle; the bit counter counts 0..WIDTH-1.
  - After the last bit: go to GAP if GAP>0, else to IDLE.
  - GAP: Y=0 for exactly GAP cycles, then IDLE.
- Bit order: MSB_FIRST=1 shifts left and sends the MSB; MSB_FIRST=0 shifts right and sends the LSB.
- Back-to-back: with Valido held high, exactly one IDLE cycle exists between words; acceptance occurs in that cycle. Line period per word = WIDTH+GAP+1 cycles.
- Counter widths: bit counter is $clog2(WIDTH+1) bits; gap counter is $clog2(GAP+1) bits, minimum 1. No wrap is possible within legal ranges.
- Fim and Y are registered together, so they are aligned.

Optional Feature:
- Macro: TRANSMISSOR_SERIAL_PARIDADE_EN.
- Defined:
  - One extra bit is sent after the data bits: the even-parity bit = XOR of the captured word, so the total count of ones is even.
  - Fim moves to the parity-bit cycle. Line period per word = WIDTH+GAP+2.
  - The parity bit is computed at acceptance and stored in a 1-bit register.
- Undefined: no parity logic or register exists; timing is as in Behaviour.

Decomposition:
- Shared package transmissor_serial_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, GAP} estado_tx_t.
  - Localparam-style helper constants: default WIDTH, default GAP.
- No sub-module. A single flat module with one always_ff for state and registers and one always_comb for next-state and Pronto.

Test Plan:
1. Defaults (WIDTH=8, GAP=2, MSB_FIRST=1): Rst low 2 cycles, then release. Require Y=0, Pronto=1, Ocupado=0, Fim=0.
2. Send Dado=8'hA0 accepted at edge k. Require Y = 1,0,1,0,0,0,0,0 in cycles k+1..k+8, Fim=1 only in k+8, Y=0 in k+9..k+10, Pronto=1 at k+11. Feed Y to the detector and require its Z to pulse exactly once.
3. Valido held high with words 8'hFF then 8'h01. Require the second word's first bit at cycle k+12 (period 11). Dado/Valido pulses during SHIFT are ignored, with no extra word sent.
4. Rst asserted during bit 4 of 8'hFF. Require Y=0 and Fim=0 asynchronously; after release Pronto=1, and the next word 8'h81 is sent cleanly as 1,0,0,0,0,0,0,1.
5. MSB_FIRST=0, GAP=0, Dado=8'h03. Require Y = 1,1,0,0,0,0,0,0, then one IDLE cycle before the next acceptance.
6. TRANSMISSOR_SERIAL_PARIDADE_EN defined, Dado=8'h07. Require 8 data bits, then parity bit 1 in cycle k+9 with Fim=1 there. For Dado=8'h03 the parity bit is 0.

Source files
------------

// File: rtl/transmissor_serial_pkg.sv
// Shared types and default parameters for the parallel-to-serial transmitter.
package transmissor_serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } estado_tx_t;

  localparam int WIDTH_PADRAO = 8;
  localparam int GAP_PADRAO   = 2;

endpackage

// File: rtl/transmissor_serial.sv
// Parallel-to-serial bit-stream transmitter.
// A word accepted over Valido/Pronto is shifted out on Y, one bit per Clk,
// followed by GAP idle-zero cycles. Fim marks the cycle the last bit is on Y.
// Optional macro TRANSMISSOR_SERIAL_PARIDADE_EN appends an even-parity bit
// after the data bits; Fim then marks the parity-bit cycle.
//
// state | meaning
// IDLE  | Y=0, Pronto=1, waiting for Valido
// SHIFT | one word bit (or the parity bit) on Y per cycle
// GAP   | Y=0 for GAP cycles before returning to IDLE
module transmissor_serial
  import transmissor_serial_pkg::*;
#(
  parameter int WIDTH     = WIDTH_PADRAO,
  parameter int GAP       = GAP_PADRAO,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Dado,
  input  logic             Valido,
  output logic             Pronto,
  output logic             Y,
  output logic             Ocupado,
  output logic             Fim
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
`ifdef TRANSMISSOR_SERIAL_PARIDADE_EN
  localparam int ULTIMO = WIDTH;
`else
  localparam int ULTIMO = WIDTH - 1;
`endif
  // bit_cnt holds the send-order index of the bit currently on Y
  localparam logic [CNT_W-1:0] ULTIMO_C      = CNT_W'(ULTIMO);
  localparam logic [CNT_W-1:0] PENULT_C      = CNT_W'(ULTIMO - 1);
  localparam logic [GAP_W-1:0] GAP_INI       = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  // The state literal GAP is hidden by the parameter GAP, so it is named
  // through the package wherever the state is meant.
  estado_tx_t       estado, estado_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nx;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nx;
  logic             y_q, y_nx;
  logic             fim_q, fim_nx;
`ifdef TRANSMISSOR_SERIAL_PARIDADE_EN
  localparam logic [CNT_W-1:0] ULT_DADO_C = CNT_W'(WIDTH - 1);
  logic             paridade, paridade_nx;
`endif

  // Next-state, next-register values and the Pronto decode.
  always_comb begin
    estado_nx  = estado;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    gap_cnt_nx = gap_cnt;
    y_nx       = 1'b0;
    fim_nx     = 1'b0;
`ifdef TRANSMISSOR_SERIAL_PARIDADE_EN
    paridade_nx = paridade;
`endif
    Pronto     = (estado == IDLE);
    case (estado)
      IDLE: begin
        if (Valido) begin
          estado_nx  = SHIFT;
          bit_cnt_nx = '0;
          // first bit goes straight to Y so it appears the cycle after acceptance
          if (MSB_FIRST) begin
            y_nx     = Dado[WIDTH-1];
            shreg_nx = Dado << 1;
          end else begin
            y_nx     = Dado[0];
            shreg_nx = Dado >> 1;
          end
`ifdef TRANSMISSOR_SERIAL_PARIDADE_EN
          paridade_nx = ^Dado;
`endif
        end
      end
      SHIFT: begin
        if (bit_cnt == ULTIMO_C) begin
          bit_cnt_nx = '0;
          if (GAP > 0) begin
            estado_nx  = transmissor_serial_pkg::GAP;
            gap_cnt_nx = GAP_INI;
          end else begin
            estado_nx = IDLE;
          end
        end else begin
          bit_cnt_nx = bit_cnt + CNT_W'(1);
          fim_nx     = (bit_cnt == PENULT_C);
          y_nx       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
          shreg_nx   = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
`ifdef TRANSMISSOR_SERIAL_PARIDADE_EN
          if (bit_cnt == ULT_DADO_C) y_nx = paridade;
`endif
        end
      end
      transmissor_serial_pkg::GAP: begin
        if (gap_cnt == '0) estado_nx = IDLE;
        else gap_cnt_nx = gap_cnt - GAP_W'(1);
      end
      default: estado_nx = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any word in flight.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      estado  <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      y_q     <= 1'b0;
      fim_q   <= 1'b0;
`ifdef TRANSMISSOR_SERIAL_PARIDADE_EN
      paridade <= 1'b0;
`endif
    end else begin
      estado  <= estado_nx;
      shreg   <= shreg_nx;
      bit_cnt <= bit_cnt_nx;
      gap_cnt <= gap_cnt_nx;
      y_q     <= y_nx;
      fim_q   <= fim_nx;
`ifdef TRANSMISSOR_SERIAL_PARIDADE_EN
      paridade <= paridade_nx;
`endif
    end
  end

  assign Y       = y_q;
  assign Fim     = fim_q;
  assign Ocupado = (estado != IDLE);

endmodule

// File: tb/tb_transmissor_serial.sv
// Bench for transmissor_serial: dut0 uses the defaults (8 bits, GAP=2, MSB
// first), dut1 uses GAP=0 and LSB first. A cycle-indexed model predicts Y, Fim,
// Pronto and Ocupado for both; directed sequences add literal expectations.
module tb_transmissor_serial;

  localparam int NCYC = 1024;
`ifdef TRANSMISSOR_SERIAL_PARIDADE_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 8 + PAR;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dado    [2];
  logic       valido  [2];
  logic       pronto  [2];
  logic       y       [2];
  logic       ocupado [2];
  logic       fim     [2];

  int checks = 0;
  int errors = 0;

  transmissor_serial #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b1)) u_dut0 (
    .Clk(clk), .Rst(rst), .Dado(dado[0]), .Valido(valido[0]),
    .Pronto(pronto[0]), .Y(y[0]), .Ocupado(ocupado[0]), .Fim(fim[0])
  );

  transmissor_serial #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b0)) u_dut1 (
    .Clk(clk), .Rst(rst), .Dado(dado[1]), .Valido(valido[1]),
    .Pronto(pronto[1]), .Y(y[1]), .Ocupado(ocupado[1]), .Fim(fim[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", nm, d, act, expv, $time);
    end
  endtask

  // ---------------- model: per-cycle expected line contents ----------------
  int cyc = 0;
  int ready_m [2];
  bit exp_y [2][NCYC];
  bit exp_f [2][NCYC];

  function automatic int gap_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit bit_of(input int d, input logic [7:0] w, input int i);
    if (i >= 8) return ^w;
    return (d == 0) ? w[7-i] : w[i];
  endfunction

  // Acceptance rule: a word offered while the line is free is sent starting next cycle.
  always @(posedge clk) begin
    int cur;
    cur = cyc;
    for (int d = 0; d < 2; d++) begin
      if (rst && valido[d] && cur >= ready_m[d] && cur + NB + 4 < NCYC) begin
        for (int i = 0; i < NB; i++) exp_y[d][cur+1+i] = bit_of(d, dado[d], i);
        exp_f[d][cur+NB] = 1'b1;
        ready_m[d] = cur + 1 + NB + gap_of(d);
      end
    end
    cyc = cur + 1;
  end

  // Reset discards anything scheduled from the current cycle on.
  always @(negedge rst) begin
    for (int d = 0; d < 2; d++) begin
      ready_m[d] = 0;
      for (int t = cyc; t < NCYC; t++) begin
        exp_y[d][t] = 1'b0;
        exp_f[d][t] = 1'b0;
      end
    end
  end

  logic [7:0] hist = '0;
  int det_cnt = 0;

  // Every-cycle comparison of both DUTs against the model, plus a pattern detector on dut0.
  always @(negedge clk) begin
    bit pe;
    if (cyc < NCYC) begin
      for (int d = 0; d < 2; d++) begin
        pe = (cyc >= ready_m[d]);
        chk("model_y", d, y[d], exp_y[d][cyc]);
        chk("model_fim", d, fim[d], exp_f[d][cyc]);
        chk("model_pronto", d, pronto[d], pe);
        chk("model_ocupado", d, ocupado[d], !pe);
      end
    end
    hist = {hist[6:0], y[0]};
    if (hist == 8'hA0) det_cnt++;
  end

  // ---------------- directed stimulus ----------------
  logic [21:0] sy, sf, sp;

  initial begin
    rst = 1'b0;
    valido[0] = 1'b0; valido[1] = 1'b0;
    dado[0] = '0; dado[1] = '0;
    sy = '0; sf = '0; sp = '0;

    // 1: reset for two cycles, then release
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("t1_y", 0, y[0], 1'b0);
    chk("t1_pronto", 0, pronto[0], 1'b1);
    chk("t1_ocupado", 0, ocupado[0], 1'b0);
    chk("t1_fim", 0, fim[0], 1'b0);

    // 2: single word A0
    dado[0] = 8'hA0; valido[0] = 1'b1;
    @(negedge clk);
    valido[0] = 1'b0;
    sy = '0; sf = '0; sp = '0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      sy = {sy[20:0], y[0]}; sf = {sf[20:0], fim[0]}; sp = {sp[20:0], pronto[0]};
    end
    chk("t2_y", 0, sy[11:0], 12'b101000000000);
`ifdef TRANSMISSOR_SERIAL_PARIDADE_EN
    chk("t2_fim", 0, sf[11:0], 12'b000000001000);
    chk("t2_pronto", 0, sp[11:0], 12'b000000000001);
`else
    chk("t2_fim", 0, sf[11:0], 12'b000000010000);
    chk("t2_pronto", 0, sp[11:0], 12'b000000000011);
`endif
    @(negedge clk); #1;
    chk("t2_detector", 0, det_cnt, 1);

    // 3: back-to-back FF then 01 with Valido held; a stray pulse mid-word is ignored
    dado[0] = 8'hFF; valido[0] = 1'b1;
    @(negedge clk);
    sy = '0;
    for (int i = 0; i < 22; i++) begin
      if (i > 0) @(negedge clk);
      sy = {sy[20:0], y[0]};
      if (i == 0) dado[0] = 8'h01;
      if (i == 12) valido[0] = 1'b0;
      if (i == 14) begin valido[0] = 1'b1; dado[0] = 8'h55; end
      if (i == 15) valido[0] = 1'b0;
    end
`ifdef TRANSMISSOR_SERIAL_PARIDADE_EN
    chk("t3_y", 0, sy, {8'hFF, 4'b0000, 8'h01, 1'b1, 1'b0});
`else
    chk("t3_y", 0, sy, {8'hFF, 3'b000, 8'h01, 3'b000});
`endif
    repeat (4) @(negedge clk);
    chk("t3_no_extra", 0, ocupado[0], 1'b0);

    // 4: reset during bit 4 of FF, then a clean 81
    dado[0] = 8'hFF; valido[0] = 1'b1;
    @(negedge clk);
    valido[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t4_async_y", 0, y[0], 1'b0);
    chk("t4_async_fim", 0, fim[0], 1'b0);
    chk("t4_async_ocupado", 0, ocupado[0], 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("t4_pronto", 0, pronto[0], 1'b1);
    chk("t4_y_idle", 0, y[0], 1'b0);
    dado[0] = 8'h81; valido[0] = 1'b1;
    @(negedge clk);
    valido[0] = 1'b0;
    sy = '0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      sy = {sy[20:0], y[0]};
    end
    chk("t4_y", 0, sy[7:0], 8'h81);

    // 5: dut1 (LSB first, GAP=0): 03 then 05 with Valido held
    dado[1] = 8'h03; valido[1] = 1'b1;
    @(negedge clk);
    sy = '0; sf = '0; sp = '0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      sy = {sy[20:0], y[1]}; sf = {sf[20:0], fim[1]}; sp = {sp[20:0], pronto[1]};
      if (i == 0) dado[1] = 8'h05;
      if (i == 10) valido[1] = 1'b0;
    end
`ifdef TRANSMISSOR_SERIAL_PARIDADE_EN
    chk("t5_y", 1, sy[11:0], {8'b11000000, 1'b0, 1'b0, 2'b10});
    chk("t5_pronto", 1, sp[11:0], {9'b0, 1'b1, 2'b0});
    chk("t5_fim", 1, sf[11:0], {8'b0, 1'b1, 3'b0});
`else
    chk("t5_y", 1, sy[11:0], {8'b11000000, 1'b0, 3'b101});
    chk("t5_pronto", 1, sp[11:0], {8'b0, 1'b1, 3'b0});
    chk("t5_fim", 1, sf[11:0], {8'b00000001, 4'b0});
`endif

    // 6: word 07 on dut0 (parity bit 1 when enabled)
    repeat (3) @(negedge clk);
    dado[0] = 8'h07; valido[0] = 1'b1;
    @(negedge clk);
    valido[0] = 1'b0;
    sy = '0; sf = '0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      sy = {sy[20:0], y[0]}; sf = {sf[20:0], fim[0]};
    end
`ifdef TRANSMISSOR_SERIAL_PARIDADE_EN
    chk("t6_y", 0, sy[11:0], {8'h07, 1'b1, 3'b0});
    chk("t6_fim", 0, sf[11:0], {8'b0, 1'b1, 3'b0});
`else
    chk("t6_y", 0, sy[11:0], {8'h07, 4'b0});
    chk("t6_fim", 0, sf[11:0], {8'b00000001, 4'b0});
`endif

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
